// File: rtl/muldiv_seq.sv
// Radix-2 sequential multiply/divide unit producing the HI/LO pair.
// One iteration per cycle, a one-cycle sign fix-up, then a single-cycle done pulse.
module muldiv_seq #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_lo,
   output logic [WIDTH-1:0] o_hi,
   output logic             o_divzero
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

   state_e r_state, w_state_next;

   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_mag_a, r_mag_b, r_a_orig;
   logic               r_sign_a, r_sign_b, r_dz;
   logic [2*WIDTH-1:0] r_acc;
   logic [CW-1:0]      r_cnt;
   logic [WIDTH-1:0]   r_lo, r_hi;
   logic               r_divzero, r_done;

   logic               w_sign_a, w_sign_b, w_last, w_neg_res;
   logic [WIDTH-1:0]   w_abs_a, w_abs_b;
   logic [WIDTH:0]     w_mul_sum, w_rem_shift;
   logic [WIDTH+1:0]   w_diff;
   logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
   logic [WIDTH-1:0]   w_quot, w_rem, w_lo_fix, w_hi_fix;
   logic               w_dz_fix;

   assign w_sign_a = i_op[0] & i_a[WIDTH-1];
   assign w_sign_b = i_op[0] & i_b[WIDTH-1];
   assign w_abs_a  = w_sign_a ? -i_a : i_a;
   assign w_abs_b  = w_sign_b ? -i_b : i_b;
   assign w_last   = (r_cnt == CW'(WIDTH - 1));

   // Multiply: accumulator holds {partial product, remaining multiplier bits}.
   assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_mag_a} : '0);
   assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

   // Divide: accumulator holds {remainder, dividend/quotient}; the extra bit catches a borrow.
   assign w_rem_shift = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_diff      = {1'b0, w_rem_shift} - {2'b00, r_mag_b};
   assign w_div_next  = w_diff[WIDTH+1] ? {w_rem_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                        : {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_neg_res = r_sign_a ^ r_sign_b;
   assign w_prod    = (r_op[0] & w_neg_res) ? -r_acc : r_acc;
   assign w_quot    = w_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem     = r_sign_a ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_comb begin
      w_lo_fix = w_prod[WIDTH-1:0];
      w_hi_fix = w_prod[2*WIDTH-1:WIDTH];
      w_dz_fix = 1'b0;
      if (r_op[1]) begin
         if (r_dz) begin
            w_lo_fix = '1;
            w_hi_fix = r_a_orig;
            w_dz_fix = 1'b1;
         end else begin
            w_lo_fix = w_quot;
            w_hi_fix = w_rem;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= StIdle;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle:  if (i_start) w_state_next = StCalc;
         StCalc:  if (w_last)  w_state_next = StFix;
         StFix:   w_state_next = StIdle;
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_busy    = (r_state != StIdle);
      o_done    = r_done;
      o_lo      = r_lo;
      o_hi      = r_hi;
      o_divzero = r_divzero;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op      <= '0;
         r_mag_a   <= '0;
         r_mag_b   <= '0;
         r_a_orig  <= '0;
         r_sign_a  <= 1'b0;
         r_sign_b  <= 1'b0;
         r_dz      <= 1'b0;
         r_acc     <= '0;
         r_cnt     <= '0;
         r_lo      <= '0;
         r_hi      <= '0;
         r_divzero <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= (r_state == StFix);
         unique case (r_state)
            StIdle: if (i_start) begin
               r_op     <= i_op;
               r_mag_a  <= w_abs_a;
               r_mag_b  <= w_abs_b;
               r_a_orig <= i_a;
               r_sign_a <= w_sign_a;
               r_sign_b <= w_sign_b;
               r_dz     <= i_op[1] & (i_b == '0);
               r_acc    <= {{WIDTH{1'b0}}, (i_op[1] ? w_abs_a : w_abs_b)};
               r_cnt    <= '0;
            end
            StCalc: begin
               r_acc <= r_op[1] ? w_div_next : w_mul_next;
               r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            StFix: begin
               r_lo      <= w_lo_fix;
               r_hi      <= w_hi_fix;
               r_divzero <= w_dz_fix;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed scenarios plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_seq;

   localparam int W = 32;
   localparam int LAT = 34;

   logic          clk = 1'b0;
   logic          reset;
   logic          i_start;
   logic [1:0]    i_op;
   logic [W-1:0]  i_a, i_b;
   logic          o_busy, o_done, o_divzero;
   logic [W-1:0]  o_lo, o_hi;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   muldiv_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_start   (i_start),
      .i_op      (i_op),
      .i_a       (i_a),
      .i_b       (i_b),
      .o_busy    (o_busy),
      .o_done    (o_done),
      .o_lo      (o_lo),
      .o_hi      (o_hi),
      .o_divzero (o_divzero)
   );

   function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] lo, output logic [31:0] hi, output logic dz);
      longint sa, sb, q, r;
      logic [63:0] p;
      dz = 1'b0;
      lo = '0;
      hi = '0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (op)
         2'b00: begin p = {32'b0, a} * {32'b0, b}; lo = p[31:0]; hi = p[63:32]; end
         2'b01: begin p = sa * sb; lo = p[31:0]; hi = p[63:32]; end
         default: begin
            if (b == 32'd0) begin
               lo = '1; hi = a; dz = 1'b1;
            end else if (op == 2'b10) begin
               lo = a / b; hi = a % b;
            end else begin
               q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0];
            end
         end
      endcase
   endfunction

   // Called at a falling edge; returns at the falling edge of the done cycle (lat==0 on timeout).
   task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit inject, output int lat, output bit busy_ok,
                         output logic [31:0] lo, output logic [31:0] hi, output logic dz);
      i_start = 1'b1; i_op = op; i_a = a; i_b = b;
      @(posedge clk);
      @(negedge clk);
      lat = 0;
      busy_ok = 1'b1;
      for (int n = 1; n <= 100; n++) begin
         if (o_done === 1'b1) begin
            lat = n;
            break;
         end
         if (o_busy !== 1'b1) busy_ok = 1'b0;
         if (inject) begin
            i_op = 2'($urandom); i_a = $urandom; i_b = $urandom;
            i_start = (n == 5 || n == 20);
         end else begin
            i_start = 1'b0;
         end
         @(negedge clk);
      end
      i_start = 1'b0;
      lo = o_lo; hi = o_hi; dz = o_divzero;
   endtask

   task automatic test_reset();
      reset = 1'b1; i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_tests += 5;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b exp 0", o_busy); end
      if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset done got %b exp 0", o_done); end
      if (o_lo !== 32'd0) begin n_fail++; $display("FAIL reset lo got %h exp 0", o_lo); end
      if (o_hi !== 32'd0) begin n_fail++; $display("FAIL reset hi got %h exp 0", o_hi); end
      if (o_divzero !== 1'b0) begin n_fail++; $display("FAIL reset divzero got %b exp 0", o_divzero); end
   endtask

   task automatic test_multu_latency();
      int lat; bit bok; logic [31:0] lo, hi; logic dz;
      run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 6;
      if (lat != LAT) begin n_fail++; $display("FAIL multu latency got %0d exp %0d", lat, LAT); end
      if (bok !== 1'b1) begin n_fail++; $display("FAIL multu busy got low exp high while running"); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL multu busy_at_done got %b exp 0", o_busy); end
      if (hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu hi got %h exp fffffffe", hi); end
      if (lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu lo got %h exp 00000001", lo); end
      if (dz !== 1'b0) begin n_fail++; $display("FAIL multu divzero got %b exp 0", dz); end
      @(negedge clk);
      n_tests += 2;
      if (o_done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b exp 0", o_done); end
      if (o_lo !== 32'h0000_0001) begin n_fail++; $display("FAIL lo_hold got %h exp 00000001", o_lo); end
   endtask

   task automatic test_mult_back_to_back();
      int lat; bit bok; logic [31:0] lo, hi; logic dz;
      run_op(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 3;
      if (lat != LAT) begin n_fail++; $display("FAIL mult latency got %0d exp %0d", lat, LAT); end
      if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult hi got %h exp ffffffff", hi); end
      if (lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult lo got %h exp ffffffeb", lo); end
      run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 3;
      if (lat != LAT) begin n_fail++; $display("FAIL b2b latency got %0d exp %0d", lat, LAT); end
      if (hi !== 32'h4000_0000) begin n_fail++; $display("FAIL b2b hi got %h exp 40000000", hi); end
      if (lo !== 32'h0) begin n_fail++; $display("FAIL b2b lo got %h exp 0", lo); end
   endtask

   task automatic test_div();
      int lat; bit bok; logic [31:0] lo, hi; logic dz;
      run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 2;
      if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_neg lo got %h exp fffffffd", lo); end
      if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_neg hi got %h exp ffffffff", hi); end
      run_op(2'b10, 32'd7, 32'd2, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 2;
      if (lo !== 32'd3) begin n_fail++; $display("FAIL divu lo got %h exp 3", lo); end
      if (hi !== 32'd1) begin n_fail++; $display("FAIL divu hi got %h exp 1", hi); end
      run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 3;
      if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf lo got %h exp 80000000", lo); end
      if (hi !== 32'h0) begin n_fail++; $display("FAIL div_ovf hi got %h exp 0", hi); end
      if (dz !== 1'b0) begin n_fail++; $display("FAIL div_ovf divzero got %b exp 0", dz); end
   endtask

   task automatic test_divzero();
      int lat; bit bok; logic [31:0] lo, hi; logic dz;
      run_op(2'b10, 32'd100, 32'd0, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 4;
      if (lat != LAT) begin n_fail++; $display("FAIL dz latency got %0d exp %0d", lat, LAT); end
      if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL dz lo got %h exp ffffffff", lo); end
      if (hi !== 32'd100) begin n_fail++; $display("FAIL dz hi got %h exp 64", hi); end
      if (dz !== 1'b1) begin n_fail++; $display("FAIL dz divzero got %b exp 1", dz); end
      repeat (3) @(negedge clk);
      n_tests++;
      if (o_divzero !== 1'b1) begin n_fail++; $display("FAIL dz_hold got %b exp 1", o_divzero); end
      run_op(2'b11, 32'hFFFF_FFFB, 32'd0, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 3;
      if (lo !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL sdz lo got %h exp ffffffff", lo); end
      if (hi !== 32'hFFFF_FFFB) begin n_fail++; $display("FAIL sdz hi got %h exp fffffffb", hi); end
      if (dz !== 1'b1) begin n_fail++; $display("FAIL sdz divzero got %b exp 1", dz); end
      run_op(2'b10, 32'd100, 32'd3, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 3;
      if (lo !== 32'd33) begin n_fail++; $display("FAIL div100_3 lo got %h exp 21", lo); end
      if (hi !== 32'd1) begin n_fail++; $display("FAIL div100_3 hi got %h exp 1", hi); end
      if (dz !== 1'b0) begin n_fail++; $display("FAIL div100_3 divzero got %b exp 0", dz); end
   endtask

   task automatic test_start_ignored();
      int lat, extra; bit bok; logic [31:0] lo, hi; logic dz;
      run_op(2'b00, 32'd6, 32'd7, 1'b1, lat, bok, lo, hi, dz);
      n_tests += 3;
      if (lat != LAT) begin n_fail++; $display("FAIL ign latency got %0d exp %0d", lat, LAT); end
      if (lo !== 32'd42) begin n_fail++; $display("FAIL ign lo got %h exp 2a", lo); end
      if (hi !== 32'd0) begin n_fail++; $display("FAIL ign hi got %h exp 0", hi); end
      extra = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (o_done === 1'b1) extra++;
      end
      n_tests++;
      if (extra != 0) begin n_fail++; $display("FAIL ign extra_done got %0d exp 0", extra); end
   endtask

   task automatic test_reset_mid();
      int lat, stray; bit bok; logic [31:0] lo, hi; logic dz;
      i_start = 1'b1; i_op = 2'b11; i_a = 32'hFFFF_FF00; i_b = 32'd5;
      @(posedge clk);
      @(negedge clk);
      i_start = 1'b0;
      repeat (9) @(negedge clk);
      reset = 1'b1;
      #1;
      n_tests += 5;
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid busy got %b exp 0", o_busy); end
      if (o_done !== 1'b0) begin n_fail++; $display("FAIL rst_mid done got %b exp 0", o_done); end
      if (o_lo !== 32'd0) begin n_fail++; $display("FAIL rst_mid lo got %h exp 0", o_lo); end
      if (o_hi !== 32'd0) begin n_fail++; $display("FAIL rst_mid hi got %h exp 0", o_hi); end
      if (o_divzero !== 1'b0) begin n_fail++; $display("FAIL rst_mid divzero got %b exp 0", o_divzero); end
      @(negedge clk);
      reset = 1'b0;
      stray = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (o_done === 1'b1 || o_busy === 1'b1) stray++;
      end
      n_tests++;
      if (stray != 0) begin n_fail++; $display("FAIL rst_mid stray got %0d exp 0", stray); end
      run_op(2'b10, 32'd9, 32'd4, 1'b0, lat, bok, lo, hi, dz);
      n_tests += 3;
      if (lat != LAT) begin n_fail++; $display("FAIL post_rst latency got %0d exp %0d", lat, LAT); end
      if (lo !== 32'd2) begin n_fail++; $display("FAIL post_rst lo got %h exp 2", lo); end
      if (hi !== 32'd1) begin n_fail++; $display("FAIL post_rst hi got %h exp 1", hi); end
   endtask

   task automatic test_random();
      int lat; bit bok; logic [31:0] lo, hi, elo, ehi, a, b; logic dz, edz; logic [1:0] op;
      for (int i = 0; i < 60; i++) begin
         op = 2'($urandom_range(0, 3));
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 7))
            0: b = 32'd0;
            1: b = 32'd1;
            2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            3: b = 32'($urandom_range(1, 255));
            4: a = 32'($urandom_range(0, 255));
            default: ;
         endcase
         model(op, a, b, elo, ehi, edz);
         run_op(op, a, b, 1'b0, lat, bok, lo, hi, dz);
         n_tests += 4;
         if (lat != LAT) begin n_fail++; $display("FAIL rand latency op=%0d got %0d exp %0d", op, lat, LAT); end
         if (lo !== elo) begin n_fail++; $display("FAIL rand lo op=%0d a=%h b=%h got %h exp %h", op, a, b, lo, elo); end
         if (hi !== ehi) begin n_fail++; $display("FAIL rand hi op=%0d a=%h b=%h got %h exp %h", op, a, b, hi, ehi); end
         if (dz !== edz) begin n_fail++; $display("FAIL rand divzero op=%0d a=%h b=%h got %b exp %b", op, a, b, dz, edz); end
         if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
      end
   endtask

   initial begin
      reset = 1'b1;
      i_start = 1'b0; i_op = '0; i_a = '0; i_b = '0;
      @(negedge clk);
      test_reset();
      test_multu_latency();
      test_mult_back_to_back();
      test_div();
      test_divzero();
      test_start_ignored();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
Iterative multiply/divide unit that produces the 64-bit HI/LO result pair written into the two-entry special register file (HI/LO). It replaces single-cycle combinational mult/div in the datapath with a radix-2 sequential engine. A start/busy/done handshake lets the controller stall issue until the result is ready. The done pulse is the HI/LO write enable.

Parameters:
WIDTH, 32, operand width; latency and all widths scale with it. Test values below assume 32.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  00 multu, 01 mult, 10 divu, 11 div
a  in  WIDTH  multiplicand / dividend (rs)
b  in  WIDTH  multiplier / divisor (rt)
busy  out  1  operation in progress; controller stalls on it
done  out  1  one-cycle pulse; HI/LO write enable
lo  out  WIDTH  product[WIDTH-1:0] or quotient
hi  out  WIDTH  product[2*WIDTH-1:WIDTH] or remainder
divzero  out  1  last completed divide had b==0; valid with done, held until next done

Behaviour:
- Reset (async, any state, including mid-operation): state IDLE; busy=0, done=0, lo=0, hi=0, divzero=0, counter=0. The in-flight operation is abandoned and produces no done.
- States: IDLE -> CALC -> FIX -> IDLE.
- IDLE: on an edge with start=1:
  - Capture op and a, b.
  - For signed ops, capture absolute values and record sign_a and sign_b.
  - Clear the accumulator and counter. Record dz = (b==0) for divide ops.
  - Go to CALC, busy=1.
- CALC: one iteration per cycle, exactly WIDTH cycles, counter 0..WIDTH-1.
  - Multiply: shift-add on magnitudes into a 2*WIDTH accumulator.
  - Divide: restoring division on magnitudes.
    - Shift the {remainder, quotient} pair left.
    - Trial-subtract the divisor.
    - Quotient bit = 1 when there is no borrow.
  - After the last iteration, go to FIX.
- FIX (1 cycle):
  - Signed multiply: negate the 64-bit product if sign_a^sign_b.
  - Signed divide: negate the quotient if sign_a^sign_b; the remainder takes sign_a (truncating division).
  - At the FIX edge: register lo/hi and divzero, set done=1 for exactly the following cycle, busy=0, state IDLE.
- Latency: start sampled at edge E0; busy high from E0 to E(WIDTH+1); done high in the cycle after E(WIDTH+1), i.e. the result is visible WIDTH+2 cycles after the start edge.
- Back-to-back: in the done cycle the unit is already IDLE, so a start there is accepted.
- start while busy: ignored, not queued. a, b and op changes while busy are ignored.
- Divide by zero: fixed latency (no early exit). Result lo = all ones, hi = a (original, unmodified dividend) for both div and divu; sign fixup is bypassed; divzero=1.
- Overflow: div of most-negative by -1 gives lo = 0x80000000, hi = 0, divzero=0.
- lo, hi and divzero hold their value between done pulses. Multiply results always have divzero=0.
- Arithmetic is modular at 2*WIDTH bits; no exceptions are raised.

Test Plan:
- Reset, then multu a=0xFFFFFFFF b=0xFFFFFFFF -> done exactly 34 cycles after the start edge; hi=0xFFFFFFFE, lo=0x00000001, busy high for the 33 intervening cycles.
- mult a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. Then immediate back-to-back start in the done cycle with mult 0x80000000 * 0x80000000 -> hi=0x40000000, lo=0.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 7/2 -> lo=3, hi=1. div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- divu a=100 b=0 -> lo=0xFFFFFFFF, hi=100, divzero=1, same 34-cycle latency. Then divu 100/3 -> lo=33, hi=1, divzero=0.
- Pulse start with different operands at cycles 5 and 20 of a running multu 6*7 -> ignored; single done with lo=42, hi=0.
- Assert reset at cycle 10 of a div -> busy=0, lo=hi=0 immediately with no done. A new divu 9/4 after release -> lo=2, hi=1.
